sales_order_tx: RTL and testbench

Order transmitter that feeds the sales accumulator's per-cycle `price`/`num` sampling interface. A host pushes orders through a valid/ready handshake into a small FIFO. The block issues each order as a one-cycle `price`/`num` beat and drives zeros on every other cycle, so a sink that accumulates unconditionally every clock adds nothing while the transmitter is idle. It also keeps order and unit totals so verification can cross-check the sink's running totals.

---
 rtl/sales_pkg.sv | 19 +
 rtl/sales_order_tx_if.sv | 25 ++
 rtl/sales_fifo.sv | 55 +++++
 rtl/sales_order_tx.sv | 115 +++++++++++
 tb/tb_sales_order_tx.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sales_pkg.sv
// Shared types for the sales order transmitter:
// bus widths, FSM state encoding and the FIFO entry.
package sales_pkg;

    localparam int PRICE_W = 32;
    localparam int NUM_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_t;

    typedef struct packed {
        logic [PRICE_W-1:0] price;
        logic [NUM_W-1:0]   num;
    } order_t;

endpackage

// File: rtl/sales_order_tx_if.sv
// Host-side order handshake bundle.
// The host drives the order; the transmitter answers with in_ready.
interface sales_order_tx_if;
    import sales_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [PRICE_W-1:0] in_price;
    logic [NUM_W-1:0]   in_num;

    modport master (
        output in_valid,
        output in_price,
        output in_num,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_price,
        input  in_num,
        output in_ready
    );

endinterface

// File: rtl/sales_fifo.sv
// Small order FIFO with registered occupancy.
// Pointers wrap naturally because DEPTH is a power of two.
module sales_fifo
    import sales_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  order_t                 wdata,
    input  logic                   pop,
    output order_t                 rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    order_t        mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case (1'b1)
                push && !pop: count <= count + 1'b1;
                pop && !push: count <= count - 1'b1;
                default:      count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/sales_order_tx.sv
// Order transmitter: queues host orders and issues each as a
// one-cycle price/num beat, zeros otherwise, with running totals.
module sales_order_tx
    import sales_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    sales_order_tx_if.slave    host,
    input  logic               hold,
    output logic [PRICE_W-1:0] price,
    output logic [NUM_W-1:0]   num,
    output logic               beat,
    output logic               busy,
    output logic [31:0]        sent_orders,
    output logic [31:0]        sent_units
);

    localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          gap_q;
    logic [CW-1:0]          gap_d;
    logic                   decide;
    logic                   start;
    logic                   push;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    order_t                 head;
    order_t                 wdata;
    logic [NUM_W:0]         units_sum;

    // Zero-quantity orders complete the handshake but are never queued.
    assign push  = host.in_valid && host.in_ready && (host.in_num != '0);
    assign wdata = '{price: host.in_price, num: host.in_num};

    assign host.in_ready = !full;

    sales_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wdata),
        .pop   (start),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // A beat may start wherever the FSM reaches a decision point:
    // idle, back-to-back issue, or the last cycle of the gap.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        decide  = 1'b0;
        start   = 1'b0;
        case (state_q)
            IDLE:           decide = 1'b1;
            ISSUE:          decide = (GAP == 0);
            sales_pkg::GAP: decide = (gap_q == '0);
            default:        decide = 1'b1;
        endcase
        start = decide && !empty && !hold;
        if (start) begin
            state_d = ISSUE;
        end else if (state_q == ISSUE && GAP > 0) begin
            state_d = sales_pkg::GAP;
            gap_d   = CW'((GAP > 0) ? GAP - 1 : 0);
        end else if (decide) begin
            state_d = IDLE;
        end else if (state_q == sales_pkg::GAP) begin
            gap_d = gap_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    assign units_sum = {1'b0, sent_units} + {1'b0, head.num};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            price       <= '0;
            num         <= '0;
            beat        <= 1'b0;
            sent_orders <= '0;
            sent_units  <= '0;
        end else begin
            price <= start ? head.price : '0;
            num   <= start ? head.num : '0;
            beat  <= start;
            if (start) begin
                sent_orders <= sent_orders + 1'b1;
                sent_units  <= units_sum[NUM_W] ? '1 : units_sum[NUM_W-1:0];
            end
        end
    end

    assign busy = (count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_sales_order_tx.sv
// Randomised bench for sales_order_tx: one instance with GAP=1,
// one with GAP=0, checked against a queue-based order model.
module tb_sales_order_tx;
    import sales_pkg::*;

    typedef struct {
        int          cyc;
        logic [31:0] p;
        logic [31:0] n;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hold1, hold0;
    logic [31:0] p1, n1, so1, su1;
    logic [31:0] p0, n0, so0, su0;
    logic b1, busy1, b0, busy0;

    always #5 clk = ~clk;

    sales_order_tx_if h1 ();
    sales_order_tx_if h0 ();

    sales_order_tx #(.DEPTH(4), .GAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .host(h1), .hold(hold1),
        .price(p1), .num(n1), .beat(b1), .busy(busy1),
        .sent_orders(so1), .sent_units(su1)
    );

    sales_order_tx #(.DEPTH(4), .GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .host(h0), .hold(hold0),
        .price(p0), .num(n0), .beat(b0), .busy(busy0),
        .sent_orders(so0), .sent_units(su0)
    );

    int tests = 0;
    int fails = 0;
    int idle_bad = 0;
    int cyc = 0;
    obs_t   obs1[$];
    obs_t   obs0[$];
    order_t exp1[$];
    order_t exp0[$];
    longint m_orders = 0;
    longint m_units = 0;
    longint m0_orders = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (b1) obs1.push_back('{cyc, p1, n1});
        else if (p1 != 0 || n1 != 0) idle_bad++;
        if (b0) obs0.push_back('{cyc, p0, n0});
        else if (p0 != 0 || n0 != 0) idle_bad++;
    end

    function automatic void model_add(input logic [31:0] n);
        m_orders++;
        if (m_units + longint'(n) > 64'hFFFF_FFFF) m_units = 64'hFFFF_FFFF;
        else m_units = m_units + longint'(n);
    endfunction

    task automatic push1(input logic [31:0] p, input logic [31:0] n,
                         output int acc);
        int w = 0;
        acc = -1;
        h1.in_valid = 1'b1;
        h1.in_price = p;
        h1.in_num = n;
        while (!h1.in_ready && w < 40) begin
            @(posedge clk); #1; w++;
        end
        tests++;
        if (!h1.in_ready) begin
            fails++;
            $display("FAIL push1_ready got %b want 1", h1.in_ready);
        end else begin
            @(posedge clk); #1;
            acc = cyc;
            if (n != 0) begin
                exp1.push_back('{price: p, num: n});
                model_add(n);
            end
        end
        h1.in_valid = 1'b0;
    endtask

    task automatic push0(input logic [31:0] p, input logic [31:0] n);
        int w = 0;
        h0.in_valid = 1'b1;
        h0.in_price = p;
        h0.in_num = n;
        while (!h0.in_ready && w < 40) begin
            @(posedge clk); #1; w++;
        end
        tests++;
        if (!h0.in_ready) begin
            fails++;
            $display("FAIL push0_ready got %b want 1", h0.in_ready);
        end else begin
            @(posedge clk); #1;
            if (n != 0) begin
                exp0.push_back('{price: p, num: n});
                m0_orders++;
            end
        end
        h0.in_valid = 1'b0;
    endtask

    task automatic wait_idle1(output int fall);
        int w = 0;
        while (busy1 && w < 200) begin
            @(posedge clk); #1; w++;
        end
        fall = cyc;
        tests++;
        if (busy1) begin
            fails++;
            $display("FAIL drain1 busy got %b want 0", busy1);
        end
    endtask

    task automatic wait_idle0();
        int w = 0;
        while (busy0 && w < 200) begin
            @(posedge clk); #1; w++;
        end
        tests++;
        if (busy0) begin
            fails++;
            $display("FAIL drain0 busy got %b want 0", busy0);
        end
    endtask

    task automatic test_reset();
        hold1 = 1'b0; hold0 = 1'b0;
        h1.in_valid = 1'b0; h1.in_price = '0; h1.in_num = '0;
        h0.in_valid = 1'b0; h0.in_price = '0; h0.in_num = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (h1.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got %b want 1", h1.in_ready);
        end
        tests++;
        if ({b1, busy1, p1, n1} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got %b/%b/%h/%h want zeros",
                     b1, busy1, p1, n1);
        end
        tests++;
        if ({so1, su1} !== '0) begin
            fails++;
            $display("FAIL reset_counters got %h/%h want 0/0", so1, su1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        obs1.delete(); obs0.delete();
    endtask

    task automatic test_single();
        int acc, fall;
        obs1.delete(); exp1.delete();
        push1(32'd10, 32'd3, acc);
        wait_idle1(fall);
        tests++;
        if (obs1.size() != 1) begin
            fails++;
            $display("FAIL single_count got %0d want 1", obs1.size());
        end else begin
            tests++;
            if (obs1[0].cyc != acc + 1 || obs1[0].p !== 32'd10 ||
                obs1[0].n !== 32'd3) begin
                fails++;
                $display("FAIL single_beat got c%0d %0d/%0d want c%0d 10/3",
                         obs1[0].cyc, obs1[0].p, obs1[0].n, acc + 1);
            end
        end
        tests++;
        if (fall != acc + 3) begin
            fails++;
            $display("FAIL single_busy_fall got %0d want %0d", fall, acc + 3);
        end
        tests++;
        if (so1 !== 32'(m_orders) || su1 !== 32'(m_units)) begin
            fails++;
            $display("FAIL single_totals got %0d/%0d want %0d/%0d",
                     so1, su1, m_orders, m_units);
        end
    endtask

    task automatic test_fill();
        int acc, acc5, fall;
        longint rev_o, rev_e, u_o, u_e;
        obs1.delete(); exp1.delete();
        hold1 = 1'b1;
        push1(32'd10, 32'd3, acc);
        push1(32'd20, 32'd1, acc);
        for (int i = 0; i < 2; i++)
            push1($urandom_range(1, 1000), $urandom_range(1, 500), acc);
        tests++;
        if (h1.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL fill_full_ready got %b want 0", h1.in_ready);
        end
        hold1 = 1'b0;
        push1($urandom_range(1, 1000), $urandom_range(1, 500), acc5);
        tests++;
        if (obs1.size() == 0 || acc5 <= obs1[0].cyc) begin
            fails++;
            $display("FAIL fill_fifth_after_pop got %0d want > first beat",
                     acc5);
        end
        wait_idle1(fall);
        tests++;
        if (obs1.size() != exp1.size()) begin
            fails++;
            $display("FAIL fill_count got %0d want %0d",
                     obs1.size(), exp1.size());
        end else begin
            rev_o = 0; rev_e = 0; u_o = 0; u_e = 0;
            for (int i = 0; i < obs1.size(); i++) begin
                tests++;
                if (obs1[i].p !== exp1[i].price ||
                    obs1[i].n !== exp1[i].num ||
                    (i > 0 && obs1[i].cyc - obs1[i-1].cyc != 2)) begin
                    fails++;
                    $display("FAIL fill_beat%0d got %0d/%0d c%0d want %0d/%0d",
                             i, obs1[i].p, obs1[i].n, obs1[i].cyc,
                             exp1[i].price, exp1[i].num);
                end
                rev_o += longint'(obs1[i].p) * longint'(obs1[i].n);
                u_o += longint'(obs1[i].n);
                rev_e += longint'(exp1[i].price) * longint'(exp1[i].num);
                u_e += longint'(exp1[i].num);
            end
            tests++;
            if (rev_o / u_o != rev_e / u_e) begin
                fails++;
                $display("FAIL fill_average got %0d want %0d",
                         rev_o / u_o, rev_e / u_e);
            end
        end
        tests++;
        if (so1 !== 32'(m_orders) || su1 !== 32'(m_units)) begin
            fails++;
            $display("FAIL fill_totals got %0d/%0d want %0d/%0d",
                     so1, su1, m_orders, m_units);
        end
    endtask

    task automatic test_zero_num();
        int acc;
        obs1.delete(); exp1.delete();
        push1(32'd99, 32'd0, acc);
        repeat (6) @(posedge clk);
        #1;
        tests++;
        if (obs1.size() != 0 || busy1 !== 1'b0) begin
            fails++;
            $display("FAIL zero_num beats got %0d busy %b want 0/0",
                     obs1.size(), busy1);
        end
        tests++;
        if (so1 !== 32'(m_orders) || su1 !== 32'(m_units)) begin
            fails++;
            $display("FAIL zero_num_totals got %0d/%0d want %0d/%0d",
                     so1, su1, m_orders, m_units);
        end
    endtask

    task automatic test_gap0();
        obs0.delete(); exp0.delete();
        hold0 = 1'b1;
        for (int i = 0; i < 4; i++)
            push0($urandom_range(1, 1000), $urandom_range(1, 500));
        hold0 = 1'b0;
        wait_idle0();
        tests++;
        if (obs0.size() != 4) begin
            fails++;
            $display("FAIL gap0_count got %0d want 4", obs0.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (obs0[i].p !== exp0[i].price || obs0[i].n !== exp0[i].num ||
                    (i > 0 && obs0[i].cyc - obs0[i-1].cyc != 1)) begin
                    fails++;
                    $display("FAIL gap0_beat%0d got %0d/%0d c%0d want %0d/%0d",
                             i, obs0[i].p, obs0[i].n, obs0[i].cyc,
                             exp0[i].price, exp0[i].num);
                end
            end
        end
        obs0.delete(); exp0.delete();
        hold0 = 1'b1;
        for (int i = 0; i < 4; i++)
            push0($urandom_range(1, 1000), $urandom_range(1, 500));
        hold0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        hold0 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (obs0.size() != 2) begin
            fails++;
            $display("FAIL gap0_hold_stop got %0d want 2", obs0.size());
        end
        hold0 = 1'b0;
        wait_idle0();
        tests++;
        if (obs0.size() != 4) begin
            fails++;
            $display("FAIL gap0_resume_count got %0d want 4", obs0.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (obs0[i].p !== exp0[i].price || obs0[i].n !== exp0[i].num) begin
                    fails++;
                    $display("FAIL gap0_resume%0d got %0d/%0d want %0d/%0d",
                             i, obs0[i].p, obs0[i].n,
                             exp0[i].price, exp0[i].num);
                end
            end
        end
        tests++;
        if (so0 !== 32'(m0_orders)) begin
            fails++;
            $display("FAIL gap0_orders got %0d want %0d", so0, m0_orders);
        end
    endtask

    task automatic test_saturation();
        int acc, fall;
        obs1.delete(); exp1.delete();
        push1(32'd5, 32'hFFFF_FFF0, acc);
        push1(32'd7, 32'h20, acc);
        wait_idle1(fall);
        tests++;
        if (obs1.size() != 2) begin
            fails++;
            $display("FAIL sat_count got %0d want 2", obs1.size());
        end else begin
            tests++;
            if (obs1[1].n !== 32'h20 || obs1[0].n !== 32'hFFFF_FFF0) begin
                fails++;
                $display("FAIL sat_beats got %h/%h want fffffff0/20",
                         obs1[0].n, obs1[1].n);
            end
        end
        tests++;
        if (su1 !== 32'(m_units)) begin
            fails++;
            $display("FAIL sat_units got %h want %h", su1, 32'(m_units));
        end
        tests++;
        if (so1 !== 32'(m_orders)) begin
            fails++;
            $display("FAIL sat_orders got %0d want %0d", so1, m_orders);
        end
    endtask

    task automatic test_reset_mid();
        int acc, w;
        obs1.delete(); exp1.delete();
        hold1 = 1'b1;
        for (int i = 0; i < 4; i++)
            push1($urandom_range(1, 1000), $urandom_range(1, 500), acc);
        hold1 = 1'b0;
        w = 0;
        while (!b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        tests++;
        if (b1 !== 1'b0 || busy1 !== 1'b1) begin
            fails++;
            $display("FAIL mid_in_gap got beat %b busy %b want 0/1", b1, busy1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        obs1.delete(); exp1.delete();
        m_orders = 0; m_units = 0;
        tests++;
        if ({b1, busy1, p1, n1, so1, su1} !== '0 || h1.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_async got %b/%b/%h/%h rdy %b want 0s rdy 1",
                     b1, busy1, p1, n1, h1.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        tests++;
        if (obs1.size() != 0 || busy1 !== 1'b0 || so1 !== 32'(m_orders)) begin
            fails++;
            $display("FAIL mid_no_beat got %0d beats busy %b orders %0d want 0",
                     obs1.size(), busy1, so1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_zero_num();
        test_gap0();
        test_saturation();
        test_reset_mid();
        tests++;
        if (idle_bad != 0) begin
            fails++;
            $display("FAIL idle_zero got %0d nonzero idle cycles want 0",
                     idle_bad);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
